// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: active-low font table, blank code
// and the decimal-point bit position within the cathode byte.
package seg7_scan_driver_pkg;

  localparam logic [7:0] SegOff = 8'hFF;
  localparam int unsigned DpBit = 7;

  // Segment order is {a,b,c,d,e,f,g}, 0 = segment lit.
  localparam logic [6:0] Font0 = 7'b0000001;
  localparam logic [6:0] Font1 = 7'b1001111;
  localparam logic [6:0] Font2 = 7'b0010010;
  localparam logic [6:0] Font3 = 7'b0000110;
  localparam logic [6:0] Font4 = 7'b1001100;
  localparam logic [6:0] Font5 = 7'b0100100;
  localparam logic [6:0] Font6 = 7'b0100000;
  localparam logic [6:0] Font7 = 7'b0001111;
  localparam logic [6:0] Font8 = 7'b0000000;
  localparam logic [6:0] Font9 = 7'b0000100;
  localparam logic [6:0] FontA = 7'b0001000;
  localparam logic [6:0] FontB = 7'b1100000;
  localparam logic [6:0] FontC = 7'b0110001;
  localparam logic [6:0] FontD = 7'b1000010;
  localparam logic [6:0] FontE = 7'b0110000;
  localparam logic [6:0] FontF = 7'b0111000;

  // Counter width for a 0..range-1 counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern {a..g}.
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = Font0;
    unique case (nibble)
      4'h0: segments = Font0;
      4'h1: segments = Font1;
      4'h2: segments = Font2;
      4'h3: segments = Font3;
      4'h4: segments = Font4;
      4'h5: segments = Font5;
      4'h6: segments = Font6;
      4'h7: segments = Font7;
      4'h8: segments = Font8;
      4'h9: segments = Font9;
      4'hA: segments = FontA;
      4'hB: segments = FontB;
      4'hC: segments = FontC;
      4'hD: segments = FontD;
      4'hE: segments = FontE;
      4'hF: segments = FontF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous double buffering, ghost-guard
// blanking, leading-zero suppression, per-digit DP/blank and PWM brightness.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_TICKS = 400000,
  parameter int unsigned BLANK_TICKS = 2000,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  input  logic                    LzSuppress,
  input  logic [BRIGHT_W-1:0]     Brightness,
  output logic [NUM_DIGITS-1:0]   Segment,
  output logic [7:0]              Digit,
  output logic                    FrameStart
);

  localparam int unsigned TickW = cnt_width(DIGIT_TICKS);
  localparam int unsigned SlotW = cnt_width(NUM_DIGITS);
  localparam logic [TickW-1:0] TickLast  = TickW'(DIGIT_TICKS - 1);
  localparam logic [TickW-1:0] TickBlank = TickW'(BLANK_TICKS);
  localparam logic [SlotW-1:0] SlotLast  = SlotW'(NUM_DIGITS - 1);

  logic [TickW-1:0]        tick_q, tick_d;
  logic [SlotW-1:0]        slot_q, slot_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   segment_q, segment_d;
  logic [7:0]              digit_q, digit_d;
  logic                    frame_start_q, frame_start_d;

  logic                  tick_wrap;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [6:0]            cur_font;
  logic                  pwm_on;
  logic                  digit_en;

  // Scan counters: tick within a slot, slot within a frame, free-running PWM phase.
  always_comb begin
    tick_wrap = (tick_q == TickLast);
    frame_end = tick_wrap && (slot_q == SlotLast);
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    slot_d    = slot_q;
    if (tick_wrap) begin
      slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Double buffer: the display copy only changes on the frame boundary so a frame never tears.
  // A Load coinciding with the boundary bypasses the pending copy.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    if (Load) begin
      pend_value_d = Value;
      pend_dp_d    = DpIn;
      pend_valid_d = 1'b1;
    end
    if (frame_end) begin
      if (Load) begin
        disp_value_d = Value;
        disp_dp_d    = DpIn;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_value_d = pend_value_q;
        disp_dp_d    = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // Leading-zero run scanned from the most significant digit down; digit 0 always shows.
  always_comb begin
    logic zero_run;
    lz_blank = '0;
    zero_run = LzSuppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (disp_value_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_dark   = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SlotW'(i)) begin
        cur_nibble = disp_value_q[4*i +: 4];
        cur_dp     = disp_dp_q[i];
        cur_dark   = BlankMask[i] || lz_blank[i];
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble   (cur_nibble),
    .segments (cur_font)
  );

  always_comb begin
    pwm_on   = (pwm_q < Brightness) || (&Brightness);
    digit_en = (tick_q >= TickBlank) && pwm_on && !cur_dark;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      segment_d[i] = !(digit_en && (slot_q == SlotW'(i)));
    end
    digit_d = SegOff;
    if (digit_en) begin
      digit_d[DpBit] = ~cur_dp;
      digit_d[6:0]   = cur_font;
    end
    frame_start_d = (tick_q == '0) && (slot_q == '0);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      tick_q        <= '0;
      slot_q        <= '0;
      pwm_q         <= '0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      disp_value_q  <= '0;
      disp_dp_q     <= '0;
      segment_q     <= '1;
      digit_q       <= SegOff;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      slot_q        <= slot_d;
      pwm_q         <= pwm_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      disp_value_q  <= disp_value_d;
      disp_dp_q     <= disp_dp_d;
      segment_q     <= segment_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign Segment    = segment_q;
  assign Digit      = digit_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int BW    = 2;
  localparam int FRAME = ND * DT;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  segment;
  logic [7:0]  digit;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT),
    .BRIGHT_W    (BW)
  ) dut (
    .CLK        (clk),
    .Reset      (reset),
    .Value      (value),
    .DpIn       (dp_in),
    .Load       (load),
    .BlankMask  (blank_mask),
    .LzSuppress (lz_suppress),
    .Brightness (brightness),
    .Segment    (segment),
    .Digit      (digit),
    .FrameStart (frame_start)
  );

  // Reference state: m_t counts cycles since reset release; everything else is derived from it.
  int          m_t;
  logic [15:0] m_disp;
  logic [3:0]  m_disp_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  bit          m_pv;
  logic [3:0]  exp_seg;
  logic [7:0]  exp_dig;
  logic        exp_fs;
  int          last_pos;
  bit          check_en;
  int          n_vec;
  int          n_miss;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s @pos %0d: got %b, expected %b", name, last_pos, act, req);
    end
  endtask

  // Expected registered outputs for the coming edge, then advance the reference state.
  task automatic model_edge();
    int tick, slot, pwm;
    bit en, lz, fe;
    if (reset) begin
      exp_seg  = 4'hF;
      exp_dig  = 8'hFF;
      exp_fs   = 1'b0;
      m_t      = 0;
      m_disp   = '0;
      m_disp_dp = '0;
      m_pend   = '0;
      m_pend_dp = '0;
      m_pv     = 1'b0;
      last_pos = -1;
    end else begin
      tick = m_t % DT;
      slot = (m_t / DT) % ND;
      pwm  = m_t % (1 << BW);
      lz   = 1'b0;
      if (lz_suppress && slot > 0) begin
        lz = 1'b1;
        for (int j = slot; j < ND; j++) if (m_disp[4*j +: 4] != 4'h0) lz = 1'b0;
      end
      en = (tick >= BT) && (brightness == 2'b11 || pwm < int'(brightness)) &&
           !blank_mask[slot] && !lz;
      exp_seg = 4'hF;
      exp_dig = 8'hFF;
      if (en) begin
        exp_seg[slot] = 1'b0;
        exp_dig = {~m_disp_dp[slot], font(m_disp[4*slot +: 4])};
      end
      exp_fs   = (m_t % FRAME == 0);
      last_pos = m_t % FRAME;
      fe = (m_t % FRAME == FRAME - 1);
      if (load && fe) begin
        m_disp    = value;
        m_disp_dp = dp_in;
        m_pv      = 1'b0;
      end else begin
        if (fe && m_pv) begin
          m_disp    = m_pend;
          m_disp_dp = m_pend_dp;
          m_pv      = 1'b0;
        end
        if (load) begin
          m_pend    = value;
          m_pend_dp = dp_in;
          m_pv      = 1'b1;
        end
      end
      m_t++;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (check_en) begin
      cmp("segment", 8'(segment), 8'(exp_seg));
      cmp("digit", digit, exp_dig);
      cmp("frame_start", 8'(frame_start), 8'(exp_fs));
    end
  endtask

  // Advance until the outputs just sampled belong to frame position p.
  task automatic run_to(input int p);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (last_pos != p && k < 2 * FRAME);
    if (last_pos != p) begin
      n_vec++;
      n_miss++;
      $display("FAIL run_to: position %0d not reached, at %0d", p, last_pos);
    end
  endtask

  task automatic count_frame(output int lit, output int ones, output int twos);
    lit  = 0;
    ones = 0;
    twos = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (segment != 4'hF) begin
        lit++;
        if (digit[6:0] == 7'b1001111) ones++;
        if (digit[6:0] == 7'b0010010) twos++;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lit, ones, twos;
    n_vec = 0;
    n_miss = 0;
    check_en = 1'b0;
    reset = 1'b1;
    value = '0;
    dp_in = '0;
    load = 1'b0;
    blank_mask = '0;
    lz_suppress = 1'b0;
    brightness = 2'b11;
    cycle();
    check_en = 1'b1;
    cycle();
    cmp("reset_segment", 8'(segment), 8'h0F);
    cmp("reset_digit", digit, 8'hFF);
    reset = 1'b0;
    cycle();
    cmp("fs_after_release", 8'(frame_start), 8'd1);
    run_to(0);
    cmp("fs_next_frame", 8'(frame_start), 8'd1);

    // Mid-slot reset held three cycles.
    run_to(12);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      cmp("midreset_segment", 8'(segment), 8'h0F);
      cmp("midreset_digit", digit, 8'hFF);
    end
    reset = 1'b0;
    cycle();
    cmp("fs_after_midreset", 8'(frame_start), 8'd1);

    // 12AF at full brightness.
    do_load(16'h12AF, 4'b0000);
    run_to(31);
    run_to(1);
    cmp("guard_segment", 8'(segment), 8'h0F);
    cmp("guard_digit", digit, 8'hFF);
    run_to(2);
    cmp("d0_segment", 8'(segment), 8'b0000_1110);
    cmp("d0_digit", digit, 8'b10111000);
    run_to(26);
    cmp("d3_segment", 8'(segment), 8'b0000_0111);
    cmp("d3_digit", digit, 8'b11001111);

    // Overwritten pending value never reaches the display.
    do_load(16'h4567, 4'b0000);
    run_to(31);
    run_to(10);
    do_load(16'h1111, 4'b0000);
    run_to(20);
    do_load(16'h2222, 4'b0000);
    run_to(31);
    count_frame(lit, ones, twos);
    cmp("ones_shown", 8'(ones), 8'd0);
    cmp("twos_shown", 8'(twos), 8'd24);

    // PWM duty over one frame: 6 window cycles per slot.
    brightness = 2'b01;
    run_to(31);
    count_frame(lit, ones, twos);
    cmp("lit_bright1", 8'(lit), 8'd4);
    brightness = 2'b10;
    run_to(31);
    count_frame(lit, ones, twos);
    cmp("lit_bright2", 8'(lit), 8'd8);
    brightness = 2'b00;
    run_to(31);
    count_frame(lit, ones, twos);
    cmp("lit_bright0", 8'(lit), 8'd0);
    brightness = 2'b11;

    // Leading-zero suppression.
    lz_suppress = 1'b1;
    do_load(16'h0030, 4'b0000);
    run_to(31);
    run_to(4);
    cmp("lz_d0_segment", 8'(segment), 8'b0000_1110);
    cmp("lz_d0_digit", digit, 8'b10000001);
    run_to(12);
    cmp("lz_d1_segment", 8'(segment), 8'b0000_1101);
    cmp("lz_d1_digit", digit, 8'b10000110);
    run_to(20);
    cmp("lz_d2_segment", 8'(segment), 8'h0F);
    run_to(28);
    cmp("lz_d3_segment", 8'(segment), 8'h0F);
    do_load(16'h0000, 4'b1111);
    run_to(31);
    count_frame(lit, ones, twos);
    cmp("lz_zero_lit", 8'(lit), 8'd6);
    lz_suppress = 1'b0;

    // Decimal point and live blank mask.
    blank_mask = 4'b0001;
    do_load(16'h4567, 4'b0100);
    run_to(31);
    run_to(4);
    cmp("blank_d0_segment", 8'(segment), 8'h0F);
    run_to(20);
    cmp("dp_d2_segment", 8'(segment), 8'b0000_1011);
    cmp("dp_d2_digit", digit, 8'b00100100);
    blank_mask = 4'b0000;

    // Load on the boundary cycle takes effect in the very next frame.
    run_to(30);
    do_load(16'hABCD, 4'b0000);
    run_to(2);
    cmp("boundary_load_digit", digit, 8'b11000010);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      load  = ($urandom_range(0, 5) == 0);
      for (int n = 0; n < 4; n++) begin
        value[4*n +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        blank_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        lz_suppress = 1'($urandom_range(0, 1));
        brightness  = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    reset = 1'b0;
    load  = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
